// File: rtl/shift_rotate_unit_if.sv
// Operand/result bus between the operand buses, the shift/rotate unit and the
// Z result register. The master drives a request (start, mode, a, amount) and
// the slave returns the registered result with busy/done status.
interface shift_rotate_unit_if #(
   parameter int WIDTH = 32
);
   localparam int AW = $clog2(WIDTH);

   logic             start;
   logic [2:0]       mode;
   logic [WIDTH-1:0] a;
   logic [AW-1:0]    amount;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;

   modport master (
      output start, mode, a, amount,
      input  result, busy, done
   );

   modport slave (
      input  start, mode, a, amount,
      output result, busy, done
   );
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate execution unit: SHR, SHRA, SHL, ROR, ROL on a
// WIDTH-bit operand. Mode codes 5-7 pass the operand through unchanged.
// The default build shifts min(STEP, remaining) positions per clock.
// Defining SHIFT_ROTATE_FAST_EN replaces that with a single-cycle barrel
// shift on the first SHIFT edge; STEP is then ignored.
module shift_rotate_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input logic                Clock,
   input logic                clear,
   shift_rotate_unit_if.slave bus
);
   localparam int AW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_SHR  = 3'd0,
      OP_SHRA = 3'd1,
      OP_SHL  = 3'd2,
      OP_ROR  = 3'd3,
      OP_ROL  = 3'd4
   } op_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q,   work_d;
   logic [2:0]       mode_q,   mode_d;
   logic [AW-1:0]    rem_q,    rem_d;
   logic [WIDTH-1:0] result_q, result_d;

   // Shift or rotate w by s positions. s never reaches WIDTH, and a shift by
   // WIDTH yields zero, so rotating by s=0 returns w unchanged.
   function automatic logic [WIDTH-1:0] shift_by(
      input logic [WIDTH-1:0] w,
      input logic [2:0]       m,
      input logic [AW-1:0]    s
   );
      logic [WIDTH-1:0] r;
      case (m)
         OP_SHR:  r = w >> s;
         OP_SHRA: r = $unsigned($signed(w) >>> s);
         OP_SHL:  r = w << s;
         OP_ROR:  r = (w >> s) | (w << (WIDTH - int'(s)));
         OP_ROL:  r = (w << s) | (w >> (WIDTH - int'(s)));
         default: r = w;
      endcase
      return r;
   endfunction

`ifndef SHIFT_ROTATE_FAST_EN
   // STEP clamped into the shift-amount width; when STEP >= WIDTH the
   // remaining count is always smaller, so the clamped value is never used.
   localparam logic [AW-1:0] STEP_V = AW'((STEP >= WIDTH) ? WIDTH - 1 : STEP);

   logic [AW-1:0] step_amt;

   // Positions to shift this cycle: min(STEP, rem).
   always_comb begin
      step_amt = (int'(rem_q) < STEP) ? rem_q : STEP_V;
   end
`endif

   // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
   always_comb begin
      // NOTE: every signal gets a hold default before the case so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      work_d   = work_q;
      mode_d   = mode_q;
      rem_d    = rem_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               work_d  = bus.a;
               mode_d  = bus.mode;
`ifdef SHIFT_ROTATE_FAST_EN
               rem_d   = bus.amount;
`else
               // Pass-through codes do no shifting, so they finish immediately.
               rem_d   = (bus.mode > 3'd4) ? '0 : bus.amount;
`endif
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
`ifdef SHIFT_ROTATE_FAST_EN
            work_d   = shift_by(work_q, mode_q, rem_q);
            rem_d    = '0;
            result_d = work_d;
            state_d  = ST_DONE;
`else
            if (rem_q != '0) begin
               work_d = shift_by(work_q, mode_q, step_amt);
               rem_d  = rem_q - step_amt;
            end else begin
               result_d = work_q;
               state_d  = ST_DONE;
            end
`endif
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; clear aborts any operation at once.
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         mode_q   <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register take its value
         // from the pre-edge state, independent of statement order.
         state_q  <= state_d;
         work_q   <= work_d;
         mode_q   <= mode_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Bench for shift_rotate_unit: a STEP=1 and a STEP=4 instance share clock and
// clear. Stimulus pushes the expected result and completion edge into a queue
// per instance; a negedge monitor pops and compares on every done pulse.
module tb_shift_rotate_unit;
   localparam int W = 32;

   localparam logic [2:0] M_SHR  = 3'd0;
   localparam logic [2:0] M_SHRA = 3'd1;
   localparam logic [2:0] M_SHL  = 3'd2;
   localparam logic [2:0] M_ROR  = 3'd3;
   localparam logic [2:0] M_ROL  = 3'd4;
   localparam logic [2:0] M_PASS = 3'd6;

   typedef struct {
      logic [W-1:0] res;
      int           edge_no;
   } exp_t;

   logic clk   = 1'b0;
   logic clear = 1'b1;
   int   cyc   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   exp_t q1[$];
   exp_t q4[$];

   shift_rotate_unit_if #(.WIDTH(W)) bus1 ();
   shift_rotate_unit_if #(.WIDTH(W)) bus4 ();

   shift_rotate_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
      .Clock (clk),
      .clear (clear),
      .bus   (bus1)
   );

   shift_rotate_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
      .Clock (clk),
      .clear (clear),
      .bus   (bus4)
   );

   always #5 clk = ~clk;

   // Count rising edges; read only on the falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Edges from start sample to done visibility.
   function automatic int lat(input logic [2:0] m, input int n, input int step);
`ifdef SHIFT_ROTATE_FAST_EN
      return 1;
`else
      if (m > 3'd4 || n == 0) return 1;
      return 1 + (n + step - 1) / step;
`endif
   endfunction

   // Monitor for the STEP=1 instance.
   always @(negedge clk) begin
      if (bus1.done) begin
         if (q1.size() == 0) begin
            check("dut1 done with no pending op", 32'(q1.size()), 32'd1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("dut1 result", bus1.result, e.res);
            check("dut1 done edge", 32'(cyc), 32'(e.edge_no));
         end
      end
   end

   // Monitor for the STEP=4 instance.
   always @(negedge clk) begin
      if (bus4.done) begin
         if (q4.size() == 0) begin
            check("dut4 done with no pending op", 32'(q4.size()), 32'd1);
         end else begin
            exp_t e;
            e = q4.pop_front();
            check("dut4 result", bus4.result, e.res);
            check("dut4 done edge", 32'(cyc), 32'(e.edge_no));
         end
      end
   end

   // One-cycle start pulse on the STEP=1 instance; k is the sampling edge.
   task automatic issue1(input logic [2:0] m, input logic [W-1:0] av, input logic [4:0] n,
                         input logic [W-1:0] exp_res, input bit push, output int k);
      exp_t e;
      @(negedge clk);
      bus1.start  = 1'b1;
      bus1.mode   = m;
      bus1.a      = av;
      bus1.amount = n;
      k = cyc + 1;
      if (push) begin
         e.res     = exp_res;
         e.edge_no = k + lat(m, int'(n), 1);
         q1.push_back(e);
      end
      @(negedge clk);
      bus1.start = 1'b0;
      bus1.a     = ~av;
   endtask

   task automatic issue4(input logic [2:0] m, input logic [W-1:0] av, input logic [4:0] n,
                         input logic [W-1:0] exp_res);
      exp_t e;
      @(negedge clk);
      bus4.start  = 1'b1;
      bus4.mode   = m;
      bus4.a      = av;
      bus4.amount = n;
      e.res     = exp_res;
      e.edge_no = cyc + 1 + lat(m, int'(n), 4);
      q4.push_back(e);
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   task automatic wait_idle1();
      int budget = 200;
      while (bus1.busy && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("dut1 idle timeout", {31'd0, bus1.busy}, 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_idle4();
      int budget = 200;
      while (bus4.busy && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("dut4 idle timeout", {31'd0, bus4.busy}, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int k, k2;
      exp_t e;

      bus1.start = 1'b0; bus1.mode = '0; bus1.a = '0; bus1.amount = '0;
      bus4.start = 1'b0; bus4.mode = '0; bus4.a = '0; bus4.amount = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset result", bus1.result, 32'h0);
      check("reset busy", {31'd0, bus1.busy}, 32'd0);
      check("reset done", {31'd0, bus1.done}, 32'd0);
      clear = 1'b0;

      // ROL 0x18 by 20, with busy window checks.
      issue1(M_ROL, 32'h0000_0018, 5'd20, 32'h0180_0000, 1'b1, k);
      check("rol busy after start edge", {31'd0, bus1.busy}, 32'd1);
      while (cyc < k + lat(M_ROL, 20, 1)) @(negedge clk);
      check("rol busy at done", {31'd0, bus1.busy}, 32'd1);
      @(negedge clk);
      check("rol busy after done", {31'd0, bus1.busy}, 32'd0);
      wait_idle1();

      // Directed mode vectors.
      issue1(M_ROR,  32'h0000_0012, 5'd4,  32'h2000_0001, 1'b1, k); wait_idle1();
      issue1(M_SHRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1, k); wait_idle1();
      issue1(M_SHL,  32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1, k); wait_idle1();
      issue1(M_SHR,  32'h8000_0000, 5'd31, 32'h0000_0001, 1'b1, k); wait_idle1();

      // Zero amount and pass-through.
      issue1(M_ROL,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b1, k); wait_idle1();
      issue1(M_PASS, 32'h1234_5678, 5'd9,  32'h1234_5678, 1'b1, k); wait_idle1();

      // start mid-operation is ignored.
      issue1(M_ROL, 32'h0000_0018, 5'd20, 32'h0180_0000, 1'b1, k);
      repeat (2) @(negedge clk);
      bus1.start = 1'b1;
      bus1.mode  = M_SHL;
      bus1.a     = 32'hFFFF_FFFF;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_idle1();

      // Back-to-back: start held high through DONE.
      @(negedge clk);
      bus1.start  = 1'b1;
      bus1.mode   = M_ROR;
      bus1.a      = 32'h0000_0012;
      bus1.amount = 5'd4;
      k = cyc + 1;
      e.res = 32'h2000_0001; e.edge_no = k + lat(M_ROR, 4, 1); q1.push_back(e);
      k2 = k + lat(M_ROR, 4, 1) + 2;
      @(negedge clk);
      bus1.mode   = M_ROL;
      bus1.a      = 32'h0000_0018;
      bus1.amount = 5'd20;
      e.res = 32'h0180_0000; e.edge_no = k2 + lat(M_ROL, 20, 1); q1.push_back(e);
      while (cyc < k2) @(negedge clk);
      bus1.start = 1'b0;
      wait_idle1();

      // STEP=4 instance, including a final partial step.
      issue4(M_ROL,  32'h0000_0018, 5'd20, 32'h0180_0000); wait_idle4();
      issue4(M_SHRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF); wait_idle4();

      // clear aborts an operation in flight.
      issue1(M_SHL, 32'hFFFF_FFFF, 5'd16, 32'h0, 1'b0, k);
      repeat (4) @(negedge clk);
      clear = 1'b1;
      #1;
      check("clear result", bus1.result, 32'h0);
      check("clear busy", {31'd0, bus1.busy}, 32'd0);
      check("clear done", {31'd0, bus1.done}, 32'd0);
      @(negedge clk);
      clear = 1'b0;
      issue1(M_SHL, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b1, k);
      wait_idle1();

      repeat (3) @(negedge clk);
      check("dut1 pending ops left", 32'(q1.size()), 32'd0);
      check("dut4 pending ops left", 32'(q4.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
